// File: rtl/pool_axis_tx_if.sv
// Handshake bundle between the pooling datapath, the transmitter and the M_AXIS sink.
// master: the transmitter side; slave: the datapath/sink side.
interface pool_axis_tx_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  pool_valid;
    logic [DATA_WIDTH-1:0] pool_data;
    logic                  pool_ready;
    logic                  M_AXIS_TVALID;
    logic                  M_AXIS_TREADY;
    logic [DATA_WIDTH-1:0] M_AXIS_TDATA;
    logic                  M_AXIS_TLAST;
    logic                  M_AXIS_TUSER;

    modport master (
        input  pool_valid, pool_data, M_AXIS_TREADY,
        output pool_ready, M_AXIS_TVALID, M_AXIS_TDATA, M_AXIS_TLAST, M_AXIS_TUSER
    );

    modport slave (
        output pool_valid, pool_data, M_AXIS_TREADY,
        input  pool_ready, M_AXIS_TVALID, M_AXIS_TDATA, M_AXIS_TLAST, M_AXIS_TUSER
    );
endinterface

// File: rtl/pool_axis_tx.sv
// AXI4-Stream transmitter for pooled results: small FIFO feeding a registered output
// stage, TUSER on the first beat and TLAST on the last beat of each frame.
module pool_axis_tx #(
    parameter int DATA_WIDTH = 16,
    parameter int OUT_W      = 13,
    parameter int OUT_H      = 13,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             S_AXIS_ACLK,
    input  logic             S_AXIS_ARESETN,
    pool_axis_tx_if.master   bus,
    output logic             frame_done,
    output logic             overflow
);
    localparam int FRAME_BEATS = OUT_W * OUT_H;
    localparam int CNT_W       = $clog2(FRAME_BEATS + 1);
    localparam int PTR_W       = $clog2(FIFO_DEPTH);
    localparam int OCC_W       = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      in_cnt, out_cnt;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [OCC_W-1:0]      occ;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;

    logic fifo_empty, fifo_full;
    logic accept, hs, out_free;
    logic load_fifo, load_bypass, fifo_wr, fifo_rd;
    logic last_beat;

    assign fifo_empty  = (occ == '0);
    assign fifo_full   = (occ == OCC_W'(FIFO_DEPTH));
    assign accept      = bus.pool_valid && bus.pool_ready;
    assign hs          = out_valid && bus.M_AXIS_TREADY;
    assign out_free    = !out_valid || hs;
    // An empty FIFO lets the incoming word go straight into the output register.
    assign load_fifo   = out_free && !fifo_empty;
    assign load_bypass = out_free && fifo_empty && accept;
    assign fifo_wr     = accept && !load_bypass;
    assign fifo_rd     = load_fifo;
    assign last_beat   = (out_cnt == CNT_W'(FRAME_BEATS - 1));

    assign bus.pool_ready    = !fifo_full && (in_cnt < CNT_W'(FRAME_BEATS)) && (state_q != DONE);
    assign bus.M_AXIS_TVALID = out_valid;
    assign bus.M_AXIS_TDATA  = out_data;
    assign bus.M_AXIS_TUSER  = out_valid && (out_cnt == '0);
    assign bus.M_AXIS_TLAST  = out_valid && last_beat;

    always_ff @(posedge S_AXIS_ACLK) begin
        if (fifo_wr) begin
            mem[wr_ptr] <= bus.pool_data;
        end
    end

    always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
        if (!S_AXIS_ARESETN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (fifo_wr) wr_ptr <= wr_ptr + PTR_W'(1);
            if (fifo_rd) rd_ptr <= rd_ptr + PTR_W'(1);
            if (fifo_wr && !fifo_rd)      occ <= occ + OCC_W'(1);
            else if (!fifo_wr && fifo_rd) occ <= occ - OCC_W'(1);
        end
    end

    always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
        if (!S_AXIS_ARESETN) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (out_free) begin
            if (load_fifo) begin
                out_valid <= 1'b1;
                out_data  <= mem[rd_ptr];
            end else if (load_bypass) begin
                out_valid <= 1'b1;
                out_data  <= bus.pool_data;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
        if (!S_AXIS_ARESETN) begin
            in_cnt   <= '0;
            out_cnt  <= '0;
            overflow <= 1'b0;
        end else begin
            if (state_q == DONE) begin
                in_cnt  <= '0;
                out_cnt <= '0;
            end else begin
                if (accept) in_cnt  <= in_cnt + CNT_W'(1);
                if (hs)     out_cnt <= out_cnt + CNT_W'(1);
            end
            if (bus.pool_valid && !bus.pool_ready) overflow <= 1'b1;
        end
    end

    always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
        if (!S_AXIS_ARESETN) state_q <= IDLE;
        else                 state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        frame_done = 1'b0;
        case (state_q)
            IDLE:    if (accept) state_d = ACTIVE;
            ACTIVE:  if (hs && last_beat) state_d = DONE;
            DONE: begin
                frame_done = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_pool_axis_tx.sv
// Scoreboard bench for pool_axis_tx: a 2x2 frame instance and a degenerate 1x1 instance.
module tb_pool_axis_tx;
    logic clk  = 1'b0;
    logic rstn = 1'b0;
    logic fd_a, ov_a, fd_b, ov_b;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [15:0] sb[$];

    always #5 clk = ~clk;

    pool_axis_tx_if #(.DATA_WIDTH(16)) a ();
    pool_axis_tx_if #(.DATA_WIDTH(16)) b ();

    pool_axis_tx #(.DATA_WIDTH(16), .OUT_W(2), .OUT_H(2), .FIFO_DEPTH(4)) dut_a (
        .S_AXIS_ACLK(clk), .S_AXIS_ARESETN(rstn), .bus(a), .frame_done(fd_a), .overflow(ov_a)
    );
    pool_axis_tx #(.DATA_WIDTH(16), .OUT_W(1), .OUT_H(1), .FIFO_DEPTH(4)) dut_b (
        .S_AXIS_ACLK(clk), .S_AXIS_ARESETN(rstn), .bus(b), .frame_done(fd_b), .overflow(ov_b)
    );

    // One clock of stimulus on instance a; the source only offers a word when ready unless forced.
    task automatic cycle_a(input logic want, input logic force_v, input logic [15:0] d, input logic r,
                           output logic acc, output logic hs, output logic tv, output logic [15:0] od,
                           output logic ou, output logic ol, output logic fd, output logic rdy);
        @(negedge clk);
        rdy = a.pool_ready;
        a.pool_valid    = force_v || (want && rdy);
        a.pool_data     = d;
        a.M_AXIS_TREADY = r;
        #1;
        acc = a.pool_valid && rdy;
        tv  = a.M_AXIS_TVALID;
        hs  = tv && r;
        od  = a.M_AXIS_TDATA;
        ou  = a.M_AXIS_TUSER;
        ol  = a.M_AXIS_TLAST;
        fd  = fd_a;
    endtask

    // Streams nframes 4-beat frames; mode 0: ready always, 1: ready low for 10 cycles, 2: random.
    task automatic drive_frames(input int nframes, input logic [15:0] base, input logic [15:0] step,
                                input int mode, output int n_user, output int n_last, output int n_fd);
        int sent = 0, beat = 0, in_frame = 0, cyc = 0, done_frames = 0;
        logic prev_last = 1'b0;
        logic acc, hs, tv, ou, ol, fd, rdy, r;
        logic [15:0] od, d, exp_d;
        n_user = 0; n_last = 0; n_fd = 0;
        while (done_frames < nframes && cyc < 400) begin
            d = base + 16'(sent) * step;
            if (mode == 0)      r = 1'b1;
            else if (mode == 1) r = (cyc >= 10);
            else                r = 1'($urandom_range(0, 1));
            cycle_a(sent < nframes * 4, 1'b0, d, r, acc, hs, tv, od, ou, ol, fd, rdy);
            if (acc) begin
                sb.push_back(d);
                sent++;
                in_frame++;
            end
            if (in_frame > 4) begin
                n_checks++;
                n_fail++;
                $display("FAIL frame_overrun: accepted %0d words in one frame, required at most 4", in_frame);
            end
            if (mode == 1 && cyc >= 2 && cyc < 10) begin
                n_checks++;
                if (tv !== 1'b1 || od !== base) begin
                    n_fail++;
                    $display("FAIL stall_hold: cyc %0d tvalid=%b tdata=%h, required 1/%h", cyc, tv, od, base);
                end
            end
            if (mode == 1 && cyc == 9) begin
                n_checks++;
                if (rdy !== 1'b0 || sent != 4) begin
                    n_fail++;
                    $display("FAIL stall_full: pool_ready=%b accepted=%0d, required 0/4", rdy, sent);
                end
            end
            n_checks++;
            if (fd !== prev_last) begin
                n_fail++;
                $display("FAIL frame_done: cyc %0d got %b, required %b", cyc, fd, prev_last);
            end
            prev_last = 1'b0;
            if (hs) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL beat_unexpected: tdata=%h with empty scoreboard", od);
                end else begin
                    exp_d = sb.pop_front();
                    if (od !== exp_d || ou !== (beat == 0) || ol !== (beat == 3)) begin
                        n_fail++;
                        $display("FAIL beat: got data=%h user=%b last=%b, required data=%h user=%b last=%b",
                                 od, ou, ol, exp_d, beat == 0, beat == 3);
                    end
                end
                if (ou) n_user++;
                if (ol) n_last++;
                prev_last = (beat == 3);
                beat = (beat + 1) % 4;
            end
            if (fd) begin
                done_frames++;
                n_fd++;
                in_frame = 0;
            end
            cyc++;
        end
        a.pool_valid = 1'b0;
        n_checks++;
        if (done_frames < nframes || sb.size() != 0) begin
            n_fail++;
            $display("FAIL stream_end: frames done %0d left %0d, required %0d frames, 0 left",
                     done_frames, sb.size(), nframes);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (a.M_AXIS_TVALID !== 1'b0 || a.M_AXIS_TDATA !== 16'h0 || a.M_AXIS_TUSER !== 1'b0 ||
            a.M_AXIS_TLAST !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_axis: v=%b d=%h u=%b l=%b, required 0/0000/0/0",
                     a.M_AXIS_TVALID, a.M_AXIS_TDATA, a.M_AXIS_TUSER, a.M_AXIS_TLAST);
        end
        n_checks++;
        if (a.pool_ready !== 1'b1 || fd_a !== 1'b0 || ov_a !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: ready=%b done=%b ovf=%b, required 1/0/0", a.pool_ready, fd_a, ov_a);
        end
        n_checks++;
        if (b.M_AXIS_TVALID !== 1'b0 || b.pool_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_b: v=%b ready=%b, required 0/1", b.M_AXIS_TVALID, b.pool_ready);
        end
        rstn = 1'b1;
    endtask

    task automatic test_basic();
        int nu, nl, nf;
        drive_frames(1, 16'h0011, 16'h0011, 0, nu, nl, nf);
        n_checks++;
        if (nu != 1 || nl != 1 || nf != 1) begin
            n_fail++;
            $display("FAIL basic_counts: user=%0d last=%0d done=%0d, required 1/1/1", nu, nl, nf);
        end
    endtask

    task automatic test_backpressure();
        int nu, nl, nf;
        drive_frames(1, 16'h0011, 16'h0011, 1, nu, nl, nf);
        n_checks++;
        if (nu != 1 || nl != 1 || nf != 1) begin
            n_fail++;
            $display("FAIL bp_counts: user=%0d last=%0d done=%0d, required 1/1/1", nu, nl, nf);
        end
    endtask

    task automatic test_back_to_back();
        int nu, nl, nf;
        drive_frames(3, 16'h0100, 16'h0001, 2, nu, nl, nf);
        n_checks++;
        if (nu != 3 || nl != 3 || nf != 3 || ov_a !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_counts: user=%0d last=%0d done=%0d ovf=%b, required 3/3/3/0", nu, nl, nf, ov_a);
        end
    endtask

    task automatic test_overflow();
        logic acc, hs, tv, ou, ol, fd, rdy;
        logic [15:0] od, exp_d;
        int cyc = 0;
        for (int i = 0; i < 4; i++) begin
            cycle_a(1'b1, 1'b0, 16'h0200 + 16'(i), 1'b0, acc, hs, tv, od, ou, ol, fd, rdy);
            if (acc) sb.push_back(16'h0200 + 16'(i));
        end
        for (int i = 0; i < 2; i++) begin
            cycle_a(1'b0, 1'b1, 16'hEEEE, 1'b0, acc, hs, tv, od, ou, ol, fd, rdy);
            n_checks++;
            if (acc !== 1'b0) begin
                n_fail++;
                $display("FAIL ovf_blocked: extra word accepted (ready=%b), required ready 0", rdy);
            end
        end
        cycle_a(1'b0, 1'b0, 16'h0, 1'b0, acc, hs, tv, od, ou, ol, fd, rdy);
        n_checks++;
        if (ov_a !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_set: overflow=%b, required 1", ov_a);
        end
        fd = 1'b0;
        while (!fd && cyc < 30) begin
            cycle_a(1'b0, 1'b0, 16'h0, 1'b1, acc, hs, tv, od, ou, ol, fd, rdy);
            if (hs) begin
                exp_d = (sb.size() != 0) ? sb.pop_front() : 16'hxxxx;
                n_checks++;
                if (od !== exp_d || od === 16'hEEEE) begin
                    n_fail++;
                    $display("FAIL ovf_drain: tdata=%h, required %h", od, exp_d);
                end
            end
            cyc++;
        end
        n_checks++;
        if (!fd || ov_a !== 1'b1 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL ovf_end: done=%b overflow=%b left=%0d, required 1/1/0", fd, ov_a, sb.size());
        end
    endtask

    task automatic test_reset_midframe();
        logic acc, hs, tv, ou, ol, fd, rdy;
        logic [15:0] od;
        int nhs = 0, nu, nl, nf;
        for (int i = 0; i < 4; i++)
            cycle_a(1'b1, 1'b0, 16'h0300 + 16'(i), 1'b0, acc, hs, tv, od, ou, ol, fd, rdy);
        for (int i = 0; i < 2; i++) begin
            cycle_a(1'b0, 1'b0, 16'h0, 1'b1, acc, hs, tv, od, ou, ol, fd, rdy);
            if (hs) nhs++;
        end
        @(negedge clk);
        a.M_AXIS_TREADY = 1'b0;
        #1;
        rstn = 1'b0;
        #1;
        n_checks++;
        if (nhs != 2 || a.M_AXIS_TVALID !== 1'b0 || a.M_AXIS_TUSER !== 1'b0 || ov_a !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset: beats sent=%0d tvalid=%b tuser=%b ovf=%b, required 2/0/0/0",
                     nhs, a.M_AXIS_TVALID, a.M_AXIS_TUSER, ov_a);
        end
        @(negedge clk);
        rstn = 1'b1;
        sb.delete();
        drive_frames(1, 16'h00A0, 16'h0001, 0, nu, nl, nf);
        n_checks++;
        if (nu != 1 || nl != 1 || nf != 1) begin
            n_fail++;
            $display("FAIL fresh_counts: user=%0d last=%0d done=%0d, required 1/1/1", nu, nl, nf);
        end
    endtask

    task automatic test_degenerate();
        @(negedge clk);
        n_checks++;
        if (b.pool_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL deg_ready: pool_ready=%b, required 1", b.pool_ready);
        end
        b.pool_valid    = 1'b1;
        b.pool_data     = 16'h005A;
        b.M_AXIS_TREADY = 1'b1;
        @(negedge clk);
        b.pool_valid = 1'b0;
        n_checks++;
        if (b.M_AXIS_TVALID !== 1'b1 || b.M_AXIS_TDATA !== 16'h005A || b.M_AXIS_TUSER !== 1'b1 ||
            b.M_AXIS_TLAST !== 1'b1) begin
            n_fail++;
            $display("FAIL deg_beat: v=%b d=%h u=%b l=%b, required 1/005a/1/1",
                     b.M_AXIS_TVALID, b.M_AXIS_TDATA, b.M_AXIS_TUSER, b.M_AXIS_TLAST);
        end
        @(negedge clk);
        n_checks++;
        if (fd_b !== 1'b1 || b.M_AXIS_TVALID !== 1'b0 || b.pool_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL deg_done: done=%b v=%b ready=%b, required 1/0/0", fd_b, b.M_AXIS_TVALID, b.pool_ready);
        end
        @(negedge clk);
        n_checks++;
        if (fd_b !== 1'b0 || b.pool_ready !== 1'b1 || ov_b !== 1'b0) begin
            n_fail++;
            $display("FAIL deg_idle: done=%b ready=%b ovf=%b, required 0/1/0", fd_b, b.pool_ready, ov_b);
        end
    endtask

    initial begin
        a.pool_valid = 1'b0; a.pool_data = '0; a.M_AXIS_TREADY = 1'b0;
        b.pool_valid = 1'b0; b.pool_data = '0; b.M_AXIS_TREADY = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_overflow();
        test_reset_midframe();
        test_degenerate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
